// File: rtl/mem_miss_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_miss_controller_pkg
// Purpose  : Shared types and constants for the cache-miss / memory-port
//            controller: FSM state encoding, refill target encodings and
//            address offset helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_miss_controller_pkg;

  // Controller states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_D_FILL  = 3'd1,
    ST_I_FILL  = 3'd2,
    ST_D_WRITE = 3'd3,
    ST_RELOOK  = 3'd4
  } state_t;

  // Refill target / last transaction owner
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  // Number of byte-offset bits inside one cache line
  function automatic int line_off_bits(input int line_words, input int data_w);
    return $clog2(line_words * data_w / 8);
  endfunction

  // Number of byte-offset bits inside one data word
  function automatic int word_off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage : mem_miss_controller_pkg
`default_nettype wire

// File: rtl/mem_miss_controller_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_miss_controller_stall_unit
// Purpose  : Combinational decode of pipeline stage enables and the ID/EX
//            bubble from the controller state and the current miss/store
//            conditions.
// Revision : 1.0 - initial release
// ============================================================================
module mem_miss_controller_stall_unit
  import mem_miss_controller_pkg::*;
(
  input  logic [2:0] state,
  input  logic       last_sel,
  input  logic       d_miss,
  input  logic       d_store,
  input  logic       i_miss,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       id_ex_bubble
);

  logic freeze;   // whole pipeline held
  logic istall;   // front end held, back end drains with a bubble
  logic d_need;   // MEM stage needs the memory port

  assign d_need = d_miss | d_store;

  // Classify the cycle as run / front-end stall / full freeze.
  // A MEM-stage store seen during an I refill also freezes: letting the
  // back end advance would drop the write-through.
  always_comb begin
    freeze = 1'b0;
    istall = 1'b0;
    case (state)
      ST_IDLE: begin
        freeze = d_need;
        istall = i_miss & ~d_need;
      end
      ST_D_FILL, ST_D_WRITE: begin
        freeze = 1'b1;
      end
      ST_I_FILL: begin
        freeze = d_need;
        istall = ~d_need;
      end
      ST_RELOOK: begin
        if (last_sel == SEL_D) begin
          freeze = 1'b1;
        end else begin
          freeze = d_need;
          istall = ~d_need;
        end
      end
      default: begin
        freeze = 1'b0;
        istall = 1'b0;
      end
    endcase
  end

  assign pc_en        = ~freeze & ~istall;
  assign if_id_en     = ~freeze & ~istall;
  assign id_ex_en     = ~freeze;
  assign ex_mem_en    = ~freeze;
  assign mem_wb_en    = ~freeze;
  assign id_ex_bubble = istall;

endmodule : mem_miss_controller_stall_unit
`default_nettype wire

// File: rtl/mem_miss_controller.sv
`default_nettype none
// ============================================================================
// Module   : mem_miss_controller
// Purpose  : Arbitrates the single main-memory port between I-cache refills,
//            D-cache refills and write-through stores, and freezes the
//            pipeline until the transaction completes and the cache re-looks.
// Revision : 1.0 - initial release
// ============================================================================
module mem_miss_controller
  import mem_miss_controller_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          if_req,
  input  logic                          if_hit,
  input  logic [ADDR_W-1:0]             if_addr,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic                          d_hit,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic                          mm_req,
  output logic                          mm_we,
  output logic [ADDR_W-1:0]             mm_addr,
  output logic [DATA_W-1:0]             mm_wdata,
  input  logic                          mm_ack,
  output logic                          refill_valid,
  output logic                          refill_sel,
  output logic [$clog2(LINE_WORDS)-1:0] refill_idx,
  output logic                          pc_en,
  output logic                          if_id_en,
  output logic                          id_ex_en,
  output logic                          ex_mem_en,
  output logic                          mem_wb_en,
  output logic                          id_ex_bubble,
  output logic [CNT_W-1:0]              i_miss_cnt,
  output logic [CNT_W-1:0]              d_miss_cnt
);

  localparam int                IDX_W      = $clog2(LINE_WORDS);
  localparam int                LINE_OFF   = line_off_bits(LINE_WORDS, DATA_W);
  localparam int                WORD_OFF   = word_off_bits(DATA_W);
  localparam logic [ADDR_W-1:0] LINE_MASK  = {ADDR_W{1'b1}} << LINE_OFF;
  localparam logic [ADDR_W-1:0] WORD_MASK  = {ADDR_W{1'b1}} << WORD_OFF;
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LINE_WORDS - 1);

  state_t              state_q, state_d;
  logic                last_sel_q, last_sel_d;
  logic                mm_req_q, mm_req_d;
  logic                mm_we_q, mm_we_d;
  logic [ADDR_W-1:0]   mm_addr_q, mm_addr_d;
  logic [DATA_W-1:0]   mm_wdata_q, mm_wdata_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]    d_cnt_q, d_cnt_d;

  logic d_miss, d_store, i_miss, ack, filling;

  assign d_miss  = d_req & ~d_we & ~d_hit;
  assign d_store = d_req & d_we;
  assign i_miss  = if_req & ~if_hit;
  // Acks outside an outstanding request are ignored
  assign ack     = mm_ack & mm_req_q;
  assign filling = (state_q == ST_D_FILL) || (state_q == ST_I_FILL);

  // Next-state, memory request and counter update
  always_comb begin
    state_d    = state_q;
    last_sel_d = last_sel_q;
    mm_req_d   = mm_req_q;
    mm_we_d    = mm_we_q;
    mm_addr_d  = mm_addr_q;
    mm_wdata_d = mm_wdata_q;
    idx_d      = idx_q;
    i_cnt_d    = i_cnt_q;
    d_cnt_d    = d_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // The MEM-stage access is the older instruction, so it wins
        if (d_miss) begin
          state_d    = ST_D_FILL;
          last_sel_d = SEL_D;
          mm_req_d   = 1'b1;
          mm_we_d    = 1'b0;
          mm_addr_d  = d_addr & LINE_MASK;
          idx_d      = '0;
          if (d_cnt_q != {CNT_W{1'b1}}) d_cnt_d = d_cnt_q + CNT_W'(1);
        end else if (d_store) begin
          state_d    = ST_D_WRITE;
          last_sel_d = SEL_D;
          mm_req_d   = 1'b1;
          mm_we_d    = 1'b1;
          mm_addr_d  = d_addr & WORD_MASK;
          mm_wdata_d = d_wdata;
        end else if (i_miss) begin
          state_d    = ST_I_FILL;
          last_sel_d = SEL_I;
          mm_req_d   = 1'b1;
          mm_we_d    = 1'b0;
          mm_addr_d  = if_addr & LINE_MASK;
          idx_d      = '0;
          if (i_cnt_q != {CNT_W{1'b1}}) i_cnt_d = i_cnt_q + CNT_W'(1);
        end
      end
      ST_D_FILL, ST_I_FILL: begin
        if (ack) begin
          idx_d     = idx_q + IDX_W'(1);
          mm_addr_d = mm_addr_q + WORD_BYTES;
          if (idx_q == LAST_IDX) begin
            mm_req_d = 1'b0;
            state_d  = ST_RELOOK;
          end
        end
      end
      ST_D_WRITE: begin
        if (ack) begin
          mm_req_d = 1'b0;
          mm_we_d  = 1'b0;
          state_d  = ST_RELOOK;
        end
      end
      ST_RELOOK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        mm_req_d = 1'b0;
        mm_we_d  = 1'b0;
      end
    endcase
  end

  // State and memory-port registers; reset aborts any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_sel_q <= SEL_I;
      mm_req_q   <= 1'b0;
      mm_we_q    <= 1'b0;
      mm_addr_q  <= '0;
      mm_wdata_q <= '0;
      idx_q      <= '0;
      i_cnt_q    <= '0;
      d_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_sel_q <= last_sel_d;
      mm_req_q   <= mm_req_d;
      mm_we_q    <= mm_we_d;
      mm_addr_q  <= mm_addr_d;
      mm_wdata_q <= mm_wdata_d;
      idx_q      <= idx_d;
      i_cnt_q    <= i_cnt_d;
      d_cnt_q    <= d_cnt_d;
    end
  end

  assign mm_req       = mm_req_q;
  assign mm_we        = mm_we_q;
  assign mm_addr      = mm_addr_q;
  assign mm_wdata     = mm_wdata_q;
  assign refill_valid = ack & filling;
  assign refill_sel   = last_sel_q;
  assign refill_idx   = idx_q;
  assign i_miss_cnt   = i_cnt_q;
  assign d_miss_cnt   = d_cnt_q;

  mem_miss_controller_stall_unit u_stall_unit (
    .state        (state_q),
    .last_sel     (last_sel_q),
    .d_miss       (d_miss),
    .d_store      (d_store),
    .i_miss       (i_miss),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .id_ex_bubble (id_ex_bubble)
  );

endmodule : mem_miss_controller
`default_nettype wire

// File: tb/tb_mem_miss_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_miss_controller
// Purpose  : Self-checking bench for mem_miss_controller. Expected bus
//            traffic, enables and counters come from a transaction-level
//            model: each miss/store is a scripted transaction whose expected
//            addresses, beats and pipeline behaviour are computed directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_miss_controller;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int LW      = 4;
  localparam int CW      = 4;   // narrow counters so saturation is reachable
  localparam int CNT_MAX = (1 << CW) - 1;

  // {pc, if_id, id_ex, ex_mem, mem_wb, bubble}
  localparam logic [5:0] EN_RUN    = 6'b111110;
  localparam logic [5:0] EN_ISTALL = 6'b001111;
  localparam logic [5:0] EN_FREEZE = 6'b000000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_hit, d_req, d_we, d_hit, mm_ack;
  logic [AW-1:0] if_addr, d_addr, mm_addr;
  logic [DW-1:0] d_wdata, mm_wdata;
  logic          mm_req, mm_we, refill_valid, refill_sel;
  logic [1:0]    refill_idx;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_bubble;
  logic [CW-1:0] i_miss_cnt, d_miss_cnt;
  logic [5:0]    en_vec;

  int total = 0;
  int bad   = 0;
  int d_exp = 0;
  int i_exp = 0;

  assign en_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_bubble};

  mem_miss_controller #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_hit(if_hit), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_hit(d_hit), .d_addr(d_addr), .d_wdata(d_wdata),
    .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_ack(mm_ack),
    .refill_valid(refill_valid), .refill_sel(refill_sel), .refill_idx(refill_idx),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .id_ex_bubble(id_ex_bubble),
    .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LW * DW / 8 - 1);
  endfunction

  // Advance one cycle, ending just after the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_hit = 1'b1; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_hit = 1'b1; d_addr = '0; d_wdata = '0;
    mm_ack = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_dcnt"}, d_miss_cnt, d_exp);
    check({tag, "_icnt"}, i_miss_cnt, i_exp);
  endtask

  // One LW-word line refill with random wait states. A D miss may be raised
  // at beat late_beat, after which the whole pipeline must freeze.
  task automatic burst(input logic sel, input logic [31:0] base, input logic [5:0] en,
                       input int late_beat, input logic [31:0] late_addr,
                       output logic [5:0] en_out);
    logic [5:0] e;
    int gap;
    e = en;
    for (int k = 0; k < LW; k++) begin
      if (k == late_beat) begin
        d_req = 1'b1; d_we = 1'b0; d_hit = 1'b0; d_addr = late_addr;
        e = EN_FREEZE;
      end
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        #1;
        check("wait_req", mm_req, 1);
        check("wait_addr", mm_addr, base + 32'(4 * k));
        check("wait_rv", refill_valid, 0);
        check("wait_en", en_vec, e);
        step();
      end
      mm_ack = 1'b1;
      #1;
      check("beat_rv", refill_valid, 1);
      check("beat_idx", refill_idx, k);
      check("beat_sel", refill_sel, sel);
      check("beat_addr", mm_addr, base + 32'(4 * k));
      check("beat_we", mm_we, 0);
      check("beat_en", en_vec, e);
      step();
      mm_ack = 1'b0;
    end
    en_out = e;
  endtask

  // D-cache read miss from IDLE through RELOOK; ends back in IDLE
  task automatic do_dmiss(input logic [31:0] a);
    logic [5:0] e;
    d_req = 1'b1; d_we = 1'b0; d_hit = 1'b0; d_addr = a;
    #1;
    check("dmiss_en", en_vec, EN_FREEZE);
    d_exp = sat_inc(d_exp);
    step();
    check_counts("dmiss");
    burst(1'b1, line_of(a), EN_FREEZE, -1, '0, e);
    #1;
    check("drelook_req", mm_req, 0);
    check("drelook_en", en_vec, EN_FREEZE);
    d_req = 1'b0; d_hit = 1'b1;
    step();
  endtask

  // I-cache miss, optionally with a D miss arriving mid-burst
  task automatic do_imiss(input logic [31:0] a, input bit late);
    logic [5:0] e;
    logic [31:0] la;
    la = $urandom;
    if_req = 1'b1; if_hit = 1'b0; if_addr = a;
    #1;
    check("imiss_en", en_vec, EN_ISTALL);
    i_exp = sat_inc(i_exp);
    step();
    check_counts("imiss");
    burst(1'b0, line_of(a), EN_ISTALL, late ? int'($urandom_range(0, LW - 1)) : -1, la, e);
    #1;
    check("irelook_req", mm_req, 0);
    check("irelook_en", en_vec, e);
    if_req = 1'b0; if_hit = 1'b1;
    step();
    if (late) do_dmiss(la);
  endtask

  // Write-through store: one memory write, pipeline frozen until ack + 1
  task automatic do_store(input logic [31:0] a, input logic [31:0] w);
    int gap;
    d_req = 1'b1; d_we = 1'b1; d_hit = 1'($urandom_range(0, 1)); d_addr = a; d_wdata = w;
    #1;
    check("st_en", en_vec, EN_FREEZE);
    step();
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      #1;
      check("st_wait_req", mm_req, 1);
      check("st_wait_en", en_vec, EN_FREEZE);
      step();
    end
    mm_ack = 1'b1;
    #1;
    check("st_req", mm_req, 1);
    check("st_we", mm_we, 1);
    check("st_addr", mm_addr, a & 32'hFFFF_FFFC);
    check("st_wdata", mm_wdata, w);
    check("st_rv", refill_valid, 0);
    step();
    mm_ack = 1'b0;
    #1;
    check("st_relook_req", mm_req, 0);
    check("st_relook_we", mm_we, 0);
    check("st_relook_en", en_vec, EN_FREEZE);
    d_req = 1'b0; d_we = 1'b0; d_hit = 1'b1;
    step();
    check_counts("st");
  endtask

  task automatic check_idle(input string tag);
    #1;
    check({tag, "_en"}, en_vec, EN_RUN);
    check({tag, "_req"}, mm_req, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req", mm_req, 0);
    check("rst_we", mm_we, 0);
    check("rst_addr", mm_addr, 0);
    check("rst_wdata", mm_wdata, 0);
    check("rst_en", en_vec, EN_RUN);
    check_counts("rst");
    rst_n = 1'b1;
    step();

    // Reset in the middle of a burst (two beats done)
    d_req = 1'b1; d_we = 1'b0; d_hit = 1'b0; d_addr = 32'h0000_0500;
    step();
    check("mid_req", mm_req, 1);
    mm_ack = 1'b1;
    step();
    step();
    mm_ack = 1'b0;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("midrst_req", mm_req, 0);
    check("midrst_en", en_vec, EN_RUN);
    check("midrst_dcnt", d_miss_cnt, 0);
    d_exp = 0; i_exp = 0;
    step();
    rst_n = 1'b1;
    step();
    check_idle("post_rst");

    // Directed: D miss at 0x1234
    do_dmiss(32'h0000_1234);
    check_idle("d1234");
    check_counts("d1234");

    // Directed: store 0xDEADBEEF to 0x40 on a hit
    do_store(32'h0000_0040, 32'hDEAD_BEEF);
    check_idle("st40");

    // Directed: I miss at 0x200
    do_imiss(32'h0000_0200, 1'b0);
    check_idle("i200");
    check_counts("i200");

    // Directed: simultaneous D and I miss; D serviced first, then I
    if_req = 1'b1; if_hit = 1'b0; if_addr = 32'h0000_0300;
    do_dmiss(32'h0000_0880);
    do_imiss(32'h0000_0300, 1'b0);
    check_idle("both");

    // Directed: D miss arriving during an I refill
    do_imiss(32'h0000_0a04, 1'b1);
    check_idle("late_d");

    // Stray ack with no request outstanding, hits only
    if_req = 1'b1; if_hit = 1'b1; d_req = 1'b1; d_hit = 1'b1; mm_ack = 1'b1;
    #1;
    check("stray_rv", refill_valid, 0);
    check("stray_en", en_vec, EN_RUN);
    step();
    clear_inputs();
    check_idle("stray");

    // Randomized transaction mix
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: do_dmiss($urandom);
        1: do_store($urandom, $urandom);
        2: do_imiss($urandom, 1'b0);
        3: do_imiss($urandom, 1'b1);
        default: begin
          if_req = 1'b1; if_hit = 1'b1; if_addr = $urandom;
          mm_ack = 1'($urandom_range(0, 1));
          step();
          clear_inputs();
        end
      endcase
      check_idle("rnd");
      check_counts("rnd");
    end

    // Drive the D counter well past its ceiling
    for (int n = 0; n < CNT_MAX + 4; n++) do_dmiss($urandom);
    check("sat_dcnt", d_miss_cnt, CNT_MAX);
    check_counts("sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_miss_controller
`default_nettype wire
